// File: rtl/uart_rx_frame_assembler.sv
// rtl/uart_rx_frame_assembler.sv - collects UART bytes into address-decoded command frames
// Frames are held on a valid/ready handshake; partial frames abort on timeout or line error.

module uart_rx_frame_assembler #(
   parameter int DATA_W      = 8,
   parameter int DATA_RX_W   = 48,
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DATA_W-1:0]    rx_data_i,
   input  logic                 rx_valid_i,
   input  logic                 rx_err_i,
   output logic [DATA_RX_W-1:0] frm_data_o,
   output logic [ADDR_W-1:0]    frm_addr_o,
   output logic [4:0]           frm_region_o,
   output logic                 frm_addr_err_o,
   output logic                 frm_valid_o,
   input  logic                 frm_ready_i,
   output logic [7:0]           drop_cnt_o,
   output logic                 busy_o
);

   localparam int N     = DATA_RX_W / DATA_W;
   localparam int CNT_W = $clog2(N + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  byte_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [ADDR_W-1:0] rx_addr;
   logic [4:0]        rx_region;
   logic              rx_addr_err;

   assign rx_addr = rx_data_i[ADDR_W-1:0];

   // Controller address map; anything above the FR_PR window is unmapped.
   always_comb begin
      rx_region = 5'd0;
      if (rx_addr <= ADDR_W'(8'h07))
         rx_region[0] = 1'b1;
      else if (rx_addr <= ADDR_W'(8'h18))
         rx_region[1] = 1'b1;
      else if (rx_addr <= ADDR_W'(8'h28))
         rx_region[2] = 1'b1;
      else if (rx_addr <= ADDR_W'(8'h3F))
         rx_region[3] = 1'b1;
      else if (rx_addr <= ADDR_W'(8'h4A))
         rx_region[4] = 1'b1;
      rx_addr_err = (rx_region == 5'd0);
   end

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         byte_cnt       <= '0;
         to_cnt         <= '0;
         frm_data_o     <= '0;
         frm_addr_o     <= '0;
         frm_region_o   <= '0;
         frm_addr_err_o <= 1'b0;
         frm_valid_o    <= 1'b0;
         drop_cnt_o     <= '0;
         busy_o         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_err_i) begin
                  drop_cnt_o <= sat_inc(drop_cnt_o);
               end else if (rx_valid_i) begin
                  frm_data_o     <= {frm_data_o[DATA_RX_W-DATA_W-1:0], rx_data_i};
                  frm_addr_o     <= rx_addr;
                  frm_region_o   <= rx_region;
                  frm_addr_err_o <= rx_addr_err;
                  byte_cnt       <= CNT_W'(1);
                  to_cnt         <= '0;
                  state          <= COLLECT;
                  busy_o         <= 1'b1;
               end
            end

            COLLECT: begin
               if (rx_err_i) begin
                  drop_cnt_o <= sat_inc(drop_cnt_o);
                  to_cnt     <= '0;
                  state      <= IDLE;
                  busy_o     <= 1'b0;
               end else if (rx_valid_i) begin
                  frm_data_o <= {frm_data_o[DATA_RX_W-DATA_W-1:0], rx_data_i};
                  to_cnt     <= '0;
                  if (byte_cnt == CNT_W'(N - 1)) begin
                     state       <= HOLD;
                     frm_valid_o <= 1'b1;
                  end else begin
                     byte_cnt <= byte_cnt + CNT_W'(1);
                  end
               end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  drop_cnt_o <= sat_inc(drop_cnt_o);
                  to_cnt     <= '0;
                  state      <= IDLE;
                  busy_o     <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            HOLD: begin
               if (frm_ready_i) begin
                  frm_valid_o <= 1'b0;
                  if (rx_err_i) begin
                     drop_cnt_o <= sat_inc(drop_cnt_o);
                     state      <= IDLE;
                     busy_o     <= 1'b0;
                  end else if (rx_valid_i) begin
                     // Byte arriving on the accept cycle opens the next frame directly.
                     frm_data_o     <= {frm_data_o[DATA_RX_W-DATA_W-1:0], rx_data_i};
                     frm_addr_o     <= rx_addr;
                     frm_region_o   <= rx_region;
                     frm_addr_err_o <= rx_addr_err;
                     byte_cnt       <= CNT_W'(1);
                     to_cnt         <= '0;
                     state          <= COLLECT;
                  end else begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end
               end else if (rx_valid_i || rx_err_i) begin
                  drop_cnt_o <= sat_inc(drop_cnt_o);
               end
            end

            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
